// File: rtl/psc_link_pkg.sv
// Framing constants and receiver FSM states shared by both ends of the PSC trigger link.
// Defaults: 50 clocks per bit, 8 data bits, trigger code 8'hA5.
package psc_link_pkg;

    localparam int unsigned    PSC_CLKS_PER_BIT = 50;
    localparam int unsigned    PSC_DATA_BITS    = 8;
    localparam logic [7:0]     PSC_TRIGGER_CODE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } psc_state_e;

endpackage

// File: rtl/psc_sync2.sv
// Two-flop synchroniser for the asynchronous PSC line.
// Both flops reset to 1, the idle level of the line.
module psc_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1_d, s1_q;
    logic s2_d, s2_q;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/psc_trigger_rx.sv
// PSC trigger link receiver: decodes start/data/stop frames from the serial line into
// a registered code, a trigger pulse on TRIGGER_CODE, a trigger counter and a frame-error pulse.
module psc_trigger_rx
    import psc_link_pkg::*;
#(
    parameter int unsigned            CLKS_PER_BIT = PSC_CLKS_PER_BIT,
    parameter int unsigned            DATA_BITS    = PSC_DATA_BITS,
    parameter logic [DATA_BITS-1:0]   TRIGGER_CODE = DATA_BITS'(PSC_TRIGGER_CODE),
    parameter int unsigned            CNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   psc_input,
    output logic                   trig_out,
    output logic                   code_valid,
    output logic [DATA_BITS-1:0]   code_out,
    output logic                   frame_error,
    output logic [CNT_WIDTH-1:0]   trig_count
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic                 line_s;
    logic                 prev_d, prev_q;
    psc_state_e           state_d, state_q;
    logic [CW-1:0]        cyc_d, cyc_q;
    logic [BW-1:0]        bit_d, bit_q;
    logic [DATA_BITS-1:0] payload_d, payload_q;
    logic                 trig_d, trig_q;
    logic                 valid_d, valid_q;
    logic [DATA_BITS-1:0] code_d, code_q;
    logic                 ferr_d, ferr_q;
    logic [CNT_WIDTH-1:0] count_d, count_q;
    logic                 sample_s;
    logic                 stop_hit_s;

    psc_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (psc_input),
        .q     (line_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Returning to IDLE at mid stop bit leaves half a cell to catch a back-to-back start edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (prev_q && !line_s) state_d = ST_START;
            ST_START:     if (cyc_q == HALF_M1) state_d = line_s ? ST_IDLE : ST_DATA;
            ST_DATA:      if ((cyc_q == FULL_M1) && (bit_q == LAST_BIT)) state_d = ST_STOP;
            ST_STOP:      if (cyc_q == FULL_M1) state_d = line_s ? ST_IDLE : ST_WAIT_IDLE;
            ST_WAIT_IDLE: if (line_s) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        prev_d     = line_s;
        sample_s   = (state_q == ST_DATA) && (cyc_q == FULL_M1);
        stop_hit_s = (state_q == ST_STOP) && (cyc_q == FULL_M1);

        if ((state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_WAIT_IDLE)) begin
            cyc_d = '0;
        end else if (cyc_q == FULL_M1) begin
            cyc_d = '0;
        end else begin
            cyc_d = cyc_q + CW'(1);
        end

        if (state_d != state_q) begin
            bit_d = '0;
        end else if (sample_s) begin
            bit_d = bit_q + BW'(1);
        end else begin
            bit_d = bit_q;
        end

        payload_d = sample_s ? {line_s, payload_q[DATA_BITS-1:1]} : payload_q;

        valid_d = stop_hit_s && line_s;
        ferr_d  = stop_hit_s && !line_s;
        trig_d  = valid_d && (payload_q == TRIGGER_CODE);
        code_d  = valid_d ? payload_q : code_q;
        count_d = trig_d ? count_q + CNT_WIDTH'(1) : count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q    <= 1'b1;
            cyc_q     <= '0;
            bit_q     <= '0;
            payload_q <= '0;
            trig_q    <= 1'b0;
            valid_q   <= 1'b0;
            code_q    <= '0;
            ferr_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            prev_q    <= prev_d;
            cyc_q     <= cyc_d;
            bit_q     <= bit_d;
            payload_q <= payload_d;
            trig_q    <= trig_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            ferr_q    <= ferr_d;
            count_q   <= count_d;
        end
    end

    assign trig_out    = trig_q;
    assign code_valid  = valid_q;
    assign code_out    = code_q;
    assign frame_error = ferr_q;
    assign trig_count  = count_q;

endmodule

// File: tb/tb_psc_trigger_rx.sv
// Directed bench for psc_trigger_rx: good frames, glitch, break, mid-frame reset,
// back-to-back frames and counter wrap on a narrow-counter instance.
module tb_psc_trigger_rx;
    import psc_link_pkg::*;

    localparam int CPB = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       psc_input = 1'b1;
    logic       trig_out, code_valid, frame_error;
    logic [7:0] code_out;
    logic [15:0] trig_count;
    logic       w_trig, w_valid, w_ferr;
    logic [7:0] w_code;
    logic [1:0] w_count;

    int n_pass = 0;
    int n_total = 0;
    int trig_n = 0, valid_n = 0, ferr_n = 0, overlap_n = 0, lone_trig_n = 0;
    time trig_times[$];
    time t_start;

    psc_trigger_rx #(.CLKS_PER_BIT(50), .DATA_BITS(8), .TRIGGER_CODE(8'hA5), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .psc_input(psc_input), .trig_out(trig_out),
        .code_valid(code_valid), .code_out(code_out), .frame_error(frame_error),
        .trig_count(trig_count));

    psc_trigger_rx #(.CLKS_PER_BIT(50), .DATA_BITS(8), .TRIGGER_CODE(8'hA5), .CNT_WIDTH(2)) dut_w (
        .clk(clk), .reset(reset), .psc_input(psc_input), .trig_out(w_trig),
        .code_valid(w_valid), .code_out(w_code), .frame_error(w_ferr),
        .trig_count(w_count));

    always #5 clk = ~clk;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (trig_out) begin
            trig_n++;
            trig_times.push_back($time);
        end
        if (code_valid) valid_n++;
        if (frame_error) ferr_n++;
        if (trig_out && frame_error) overlap_n++;
        if (trig_out && !code_valid) lone_trig_n++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic hold(input logic b, input int n);
        psc_input = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_len);
        t_start = $time;
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(d[i], CPB);
        hold(stop, stop_len);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    int t0, v0, f0;
    int lat;

    initial begin
        repeat (4) @(posedge clk);
        #1;
        check("rst_trig", {31'd0, trig_out}, 32'd0);
        check("rst_valid", {31'd0, code_valid}, 32'd0);
        check("rst_code", {24'd0, code_out}, 32'd0);
        check("rst_ferr", {31'd0, frame_error}, 32'd0);
        check("rst_count", {16'd0, trig_count}, 32'd0);
        check("rst_state", {29'd0, dut.state_q}, {29'd0, ST_IDLE});
        reset = 1'b0;
        hold(1'b1, 20);

        // 1: trigger frame and latency
        t0 = trig_n; v0 = valid_n;
        send_frame(8'hA5, 1'b1, CPB);
        hold(1'b1, 20);
        check("t1_trig", trig_n - t0, 1);
        check("t1_valid", valid_n - v0, 1);
        check("t1_code", {24'd0, code_out}, 32'hA5);
        check("t1_count", {16'd0, trig_count}, 32'd1);
        lat = int'((trig_times[trig_times.size()-1] - t_start) / 10);
        check("t1_latency", {31'd0, (lat >= 478 && lat <= 480)}, 32'd1);
        check("t1_trig_with_valid", lone_trig_n, 0);

        // 2: non-trigger frame
        t0 = trig_n; v0 = valid_n;
        send_frame(8'h3C, 1'b1, CPB);
        hold(1'b1, 20);
        check("t2_trig", trig_n - t0, 0);
        check("t2_valid", valid_n - v0, 1);
        check("t2_code", {24'd0, code_out}, 32'h3C);
        check("t2_count", {16'd0, trig_count}, 32'd1);

        // 3: short glitch rejected
        t0 = trig_n; v0 = valid_n; f0 = ferr_n;
        hold(1'b0, 10);
        hold(1'b1, 100);
        check("t3_glitch_valid", valid_n - v0, 0);
        check("t3_glitch_ferr", ferr_n - f0, 0);
        check("t3_glitch_state", {29'd0, dut.state_q}, {29'd0, ST_IDLE});
        send_frame(8'hA5, 1'b1, CPB);
        hold(1'b1, 20);
        check("t3_trig", trig_n - t0, 1);
        check("t3_code", {24'd0, code_out}, 32'hA5);
        check("t3_count", {16'd0, trig_count}, 32'd2);

        // 4: break (stop bit low, line held low)
        t0 = trig_n; v0 = valid_n; f0 = ferr_n;
        send_frame(8'hA5, 1'b0, 500);
        hold(1'b1, 60);
        check("t4_ferr", ferr_n - f0, 1);
        check("t4_trig", trig_n - t0, 0);
        check("t4_valid", valid_n - v0, 0);
        check("t4_code", {24'd0, code_out}, 32'hA5);
        v0 = valid_n;
        send_frame(8'h5A, 1'b1, CPB);
        hold(1'b1, 20);
        check("t4_next_valid", valid_n - v0, 1);
        check("t4_next_code", {24'd0, code_out}, 32'h5A);

        // 5: reset during data bit 4 of a trigger frame
        t0 = trig_n;
        hold(1'b0, CPB);
        hold(1'b1, CPB); hold(1'b0, CPB); hold(1'b1, CPB); hold(1'b0, CPB);
        hold(1'b0, 20);
        reset = 1'b1;
        hold(1'b0, 3);
        check("t5_rst_trig", {31'd0, trig_out}, 32'd0);
        check("t5_rst_valid", {31'd0, code_valid}, 32'd0);
        check("t5_rst_code", {24'd0, code_out}, 32'd0);
        check("t5_rst_count", {16'd0, trig_count}, 32'd0);
        reset = 1'b0;
        hold(1'b0, 27);
        hold(1'b1, CPB); hold(1'b0, CPB); hold(1'b1, CPB);
        hold(1'b1, 700);
        check("t5_no_trig", trig_n - t0, 0);
        send_frame(8'hA5, 1'b1, CPB);
        hold(1'b1, 20);
        check("t5_next_trig", trig_n - t0, 1);
        check("t5_next_code", {24'd0, code_out}, 32'hA5);
        check("t5_next_count", {16'd0, trig_count}, 32'd1);

        // 6: back-to-back frames and wrap of the 2-bit counter
        do_reset();
        hold(1'b1, 20);
        t0 = trig_n;
        for (int k = 0; k < 3; k++) send_frame(8'hA5, 1'b1, CPB);
        hold(1'b1, 20);
        check("t6_trig3", trig_n - t0, 3);
        check("t6_count3", {16'd0, trig_count}, 32'd3);
        check("t6_wcount3", {30'd0, w_count}, 32'd3);
        check("t6_gap1", int'((trig_times[trig_times.size()-2] - trig_times[trig_times.size()-3]) / 10), 500);
        check("t6_gap2", int'((trig_times[trig_times.size()-1] - trig_times[trig_times.size()-2]) / 10), 500);
        send_frame(8'hA5, 1'b1, CPB);
        hold(1'b1, 20);
        check("t6_count4", {16'd0, trig_count}, 32'd4);
        check("t6_wrap", {30'd0, w_count}, 32'd0);
        check("overlap", overlap_n, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
